axil_reg_slave: RTL and testbench

- Generic AXI4-Lite responder exposing REG_COUNT word-wide registers to a host-side AXI-lite master.
- Fabric logic reads them through a flat output bus and sees a per-register write pulse.
- Register 0 is a read-only identification word.
- Intended as the standard configuration/status target behind the same AXI-lite masters that drive our other peripherals.

---
 rtl/axil_reg_slave.sv | 181 ++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: REG_COUNT word registers, register 0 is a read-only ID word.
// Fabric sees all registers on a flat bus plus a one-cycle write pulse per register.
module axil_reg_slave #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned           REG_COUNT  = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h444E_4131
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
    input  logic [2:0]                       s_axil_awprot,
    input  logic                             s_axil_awvalid,
    output logic                             s_axil_awready,
    input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]            s_axil_wstrb,
    input  logic                             s_axil_wvalid,
    output logic                             s_axil_wready,
    output logic [1:0]                       s_axil_bresp,
    output logic                             s_axil_bvalid,
    input  logic                             s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
    input  logic [2:0]                       s_axil_arprot,
    input  logic                             s_axil_arvalid,
    output logic                             s_axil_arready,
    output logic [DATA_WIDTH-1:0]            s_axil_rdata,
    output logic [1:0]                       s_axil_rresp,
    output logic                             s_axil_rvalid,
    input  logic                             s_axil_rready,

    output logic [REG_COUNT*DATA_WIDTH-1:0]  regs_out,
    output logic [REG_COUNT-1:0]             reg_wr_pulse
);

    localparam int unsigned IDX_LSB = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_W   = $clog2(REG_COUNT);
    localparam int unsigned IDX_TOP = IDX_LSB + IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side state
    logic                  aw_full_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_full_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [REG_COUNT-1:0]  reg_wr_pulse_q;

    // Read-side state
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    // Decoded write/read controls
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_in_range;
    logic                  wr_ok;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;

    logic                  unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    always_comb begin
        aw_hs       = s_axil_awvalid && !aw_full_q;
        w_hs        = s_axil_wvalid && !w_full_q;
        ar_hs       = s_axil_arvalid && !rvalid_q;

        // A buffered beat takes priority over the live bus; both can't be live at once
        wr_addr     = aw_full_q ? aw_addr_q : s_axil_awaddr;
        wr_data     = w_full_q ? w_data_q : s_axil_wdata;
        wr_strb     = w_full_q ? w_strb_q : s_axil_wstrb;

        commit      = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;

        wr_idx      = wr_addr[IDX_LSB +: IDX_W];
        wr_in_range = (wr_addr >> IDX_TOP) == '0;
        wr_ok       = wr_in_range && (wr_idx != '0);

        rd_idx      = s_axil_araddr[IDX_LSB +: IDX_W];
        rd_in_range = (s_axil_araddr >> IDX_TOP) == '0;
    end

    // AW/W one-deep buffers and B channel
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_full_q <= 1'b1;
                    aw_addr_q <= s_axil_awaddr;
                end
                if (w_hs) begin
                    w_full_q <= 1'b1;
                    w_data_q <= s_axil_wdata;
                    w_strb_q <= s_axil_wstrb;
                end
                if (bvalid_q && s_axil_bready) begin
                    bvalid_q <= 1'b0;
                end
            end
        end
    end

    // Register file and write pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= (i == 0) ? ID_VALUE : '0;
            end
            reg_wr_pulse_q <= '0;
        end else begin
            reg_wr_pulse_q <= '0;
            if (commit && wr_ok) begin
                reg_wr_pulse_q[wr_idx] <= 1'b1;
                for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                    if (wr_strb[b]) begin
                        regs_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read channel; samples regs_q before any same-edge write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_in_range ? regs_q[rd_idx] : '0;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axil_awready = !aw_full_q;
    assign s_axil_wready  = !w_full_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = !rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign reg_wr_pulse   = reg_wr_pulse_q;

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave with hand-computed expectations.
module tb_axil_reg_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned RC = 16;
    localparam logic [31:0] ID = 32'h444E_4131;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  awaddr = '0;
    logic [2:0]     awprot = '0;
    logic           awvalid = 1'b0;
    logic           awready;
    logic [DW-1:0]  wdata = '0;
    logic [SW-1:0]  wstrb = '0;
    logic           wvalid = 1'b0;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready = 1'b0;
    logic [AW-1:0]  araddr = '0;
    logic [2:0]     arprot = '0;
    logic           arvalid = 1'b0;
    logic           arready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready = 1'b0;
    logic [RC*DW-1:0] regs_out;
    logic [RC-1:0]  reg_wr_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axil_reg_slave dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .regs_out       (regs_out),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Step one clock edge and settle just past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        check({tag, " arready"}, {31'd0, arready}, 32'd1);
        araddr  = addr;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check({tag, " rvalid"}, {31'd0, rvalid}, 32'd1);
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " rresp"}, {30'd0, rresp}, {30'd0, exp_resp});
        rready = 1'b1;
        step();
        rready = 1'b0;
        check({tag, " rvalid clr"}, {31'd0, rvalid}, 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input logic [15:0] exp_pulse);
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        bready  = 1'b1;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({tag, " bvalid"}, {31'd0, bvalid}, 32'd1);
        check({tag, " bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
        check({tag, " pulse"}, {16'd0, reg_wr_pulse}, {16'd0, exp_pulse});
        step();
        bready = 1'b0;
        check({tag, " bvalid clr"}, {31'd0, bvalid}, 32'd0);
        check({tag, " pulse clr"}, {16'd0, reg_wr_pulse}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst awready", {31'd0, awready}, 32'd1);
        check("rst wready", {31'd0, wready}, 32'd1);
        check("rst arready", {31'd0, arready}, 32'd1);
        check("rst bvalid", {31'd0, bvalid}, 32'd0);
        check("rst rvalid", {31'd0, rvalid}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst pulse", {16'd0, reg_wr_pulse}, 32'd0);
        check("rst reg0", regs_out[31:0], ID);
        check("rst reg1", regs_out[63:32], 32'd0);

        do_read("rd id", 32'h0, ID, 2'b00);
        do_read("rd r1", 32'h4, 32'h0, 2'b00);

        do_write("wr r2", 32'h8, 32'hA5A5_1234, 4'hF, 2'b00, 16'h0004);
        check("r2 regs_out", regs_out[95:64], 32'hA5A5_1234);
        do_read("rd r2", 32'h8, 32'hA5A5_1234, 2'b00);

        // W three cycles ahead of AW, partial strobes
        wdata  = 32'hFFFF_FFFF;
        wstrb  = 4'b0101;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("wfirst wready", {31'd0, wready}, 32'd0);
        check("wfirst bvalid", {31'd0, bvalid}, 32'd0);
        step();
        step();
        check("wfirst wready hold", {31'd0, wready}, 32'd0);
        check("wfirst bvalid hold", {31'd0, bvalid}, 32'd0);
        awaddr  = 32'hC;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("wfirst bvalid", {31'd0, bvalid}, 32'd1);
        check("wfirst bresp", {30'd0, bresp}, 32'd0);
        check("wfirst pulse", {16'd0, reg_wr_pulse}, 32'h0008);
        check("wfirst r3", regs_out[127:96], 32'h00FF_00FF);
        check("wfirst wready free", {31'd0, wready}, 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("wfirst bvalid clr", {31'd0, bvalid}, 32'd0);

        do_write("wr r0", 32'h0, 32'h1234_5678, 4'hF, 2'b10, 16'h0000);
        check("r0 kept", regs_out[31:0], ID);
        do_write("wr oor", 32'h40, 32'hDEAD_BEEF, 4'hF, 2'b10, 16'h0000);
        do_read("rd oor", 32'h40, 32'h0, 2'b10);
        do_read("rd id2", 32'h0, ID, 2'b00);

        // B backpressure with a second write buffered behind the first
        awaddr  = 32'h14;
        awvalid = 1'b1;
        wdata   = 32'h1111_1111;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        step();
        check("bp first bvalid", {31'd0, bvalid}, 32'd1);
        check("bp r5", regs_out[191:160], 32'h1111_1111);
        awaddr = 32'h18;
        wdata  = 32'h2222_2222;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("bp awready", {31'd0, awready}, 32'd0);
        check("bp wready", {31'd0, wready}, 32'd0);
        repeat (3) step();
        check("bp bvalid hold", {31'd0, bvalid}, 32'd1);
        check("bp bresp hold", {30'd0, bresp}, 32'd0);
        check("bp r6 untouched", regs_out[223:192], 32'd0);
        check("bp pulse quiet", {16'd0, reg_wr_pulse}, 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bp bvalid gap", {31'd0, bvalid}, 32'd0);
        step();
        check("bp second bvalid", {31'd0, bvalid}, 32'd1);
        check("bp second pulse", {16'd0, reg_wr_pulse}, 32'h0040);
        check("bp r6", regs_out[223:192], 32'h2222_2222);
        check("bp awready free", {31'd0, awready}, 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bp second clr", {31'd0, bvalid}, 32'd0);

        // Read and write to register 4 on the same edge
        do_write("wr r4 old", 32'h10, 32'h7, 4'hF, 2'b00, 16'h0010);
        araddr  = 32'h10;
        arvalid = 1'b1;
        awaddr  = 32'h10;
        awvalid = 1'b1;
        wdata   = 32'h1;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        bready  = 1'b1;
        step();
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("coll rvalid", {31'd0, rvalid}, 32'd1);
        check("coll rdata", rdata, 32'h7);
        check("coll bvalid", {31'd0, bvalid}, 32'd1);
        check("coll r4", regs_out[159:128], 32'h1);
        rready = 1'b1;
        step();
        rready = 1'b0;
        bready = 1'b0;
        do_read("rd r4 new", 32'h10, 32'h1, 2'b00);

        // Reset with only W buffered must drop it
        wdata  = 32'h9999_9999;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("mid wready", {31'd0, wready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid rst wready", {31'd0, wready}, 32'd1);
        check("mid rst r2", regs_out[95:64], 32'd0);
        awaddr  = 32'h14;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("mid no commit", {31'd0, bvalid}, 32'd0);
        check("mid r5 zero", regs_out[191:160], 32'd0);
        wdata  = 32'h5;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("mid bvalid", {31'd0, bvalid}, 32'd1);
        check("mid r5", regs_out[191:160], 32'h5);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("mid bvalid clr", {31'd0, bvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
